sensor_okuyucu: RTL and testbench

Serial temperature-sensor reader: the producer side of the 7-bit `sicaklik` sample stream that the averaging/alarm logic consumes.
- Periodically polls an external serial sensor, generating chip-select and serial clock.
- Shifts in an 8-bit frame (7 data bits + odd parity), checks it, and presents a held 7-bit sample with a one-cycle valid pulse.
- Sits between the board sensor pins and the alarm datapath.

---
 rtl/sensor_okuyucu_pkg.sv | 10 +
 rtl/sensor_okuyucu_if.sv | 12 +
 rtl/sensor_okuyucu_sclk_tick.sv | 17 +
 rtl/sensor_okuyucu.sv | 80 ++++++++
 tb/tb_sensor_okuyucu.sv | 112 +++++++++++
 5 files changed

// File: rtl/sensor_okuyucu_pkg.sv
// sensor_okuyucu_pkg: shared state encoding, frame sizes and PERIOD legality helper
package sensor_okuyucu_pkg;
  typedef enum logic [1:0] {BEKLE, SECIM, KAYDIR, BITIR} durum_e;
  localparam int FRAME_BITS = 8;
  localparam int DATA_BITS = 7;
  // A frame needs CLK_DIV (select) + 16*CLK_DIV (shift) + BITIR + one idle cycle to restart
  function automatic int min_period(input int clk_div);
    return 17 * clk_div + 2;
  endfunction
endpackage

// File: rtl/sensor_okuyucu_if.sv
// sensor_okuyucu_if: sensor pins (sdo, cs_n, sclk) and sample stream (sicaklik, gecerli, hata); master = reader
interface sensor_okuyucu_if;
  import sensor_okuyucu_pkg::*;
  logic sensor_sdo;
  logic sensor_cs_n;
  logic sensor_sclk;
  logic [DATA_BITS-1:0] sicaklik;
  logic gecerli;
  logic hata;
  modport master(input sensor_sdo, output sensor_cs_n, sensor_sclk, sicaklik, gecerli, hata);
  modport slave(output sensor_sdo, input sensor_cs_n, sensor_sclk, sicaklik, gecerli, hata);
endinterface

// File: rtl/sensor_okuyucu_sclk_tick.sv
// sensor_okuyucu_sclk_tick: one-cycle tick every CLK_DIV enabled cycles; ports saat, reset, en in, tick out
module sensor_okuyucu_sclk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic saat,
  input  logic reset,
  input  logic en,
  output logic tick
);
  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);
  logic [7:0] cnt_q, cnt_d;
  assign tick = en && cnt_q == LAST;
  always_comb cnt_d = (!en || tick) ? 8'd0 : cnt_q + 8'd1;
  always_ff @(posedge saat or posedge reset)
    if (reset) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sensor_okuyucu.sv
// sensor_okuyucu: polls a serial sensor every PERIOD cycles; ports saat, reset, bus (sdo in; cs_n, sclk, sicaklik, gecerli, hata out)
module sensor_okuyucu
  import sensor_okuyucu_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int PERIOD  = 80
) (
  input logic saat,
  input logic reset,
  sensor_okuyucu_if.master bus
);
  if (CLK_DIV < 1 || CLK_DIV > 255 || PERIOD < min_period(CLK_DIV)) begin : g_bad_param
    $error("sensor_okuyucu: illegal CLK_DIV/PERIOD combination");
  end
  localparam int PW = $clog2(PERIOD);
  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);
  logic [PW-1:0] per_q, per_d;
  durum_e state_q;
  logic [3:0] half_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] sicaklik_q;
  logic cs_n_q, sclk_q, gecerli_q, hata_q, tick;
  sensor_okuyucu_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .saat (saat),
    .reset(reset),
    .en   (state_q == SECIM || state_q == KAYDIR),
    .tick (tick)
  );
  always_comb per_d = (per_q == PER_LAST) ? '0 : per_q + PW'(1);
  always_ff @(posedge saat or posedge reset)
    if (reset) per_q <= '0;
    else per_q <= per_d;
  always_ff @(posedge saat or posedge reset)
    if (reset) begin
      state_q    <= BEKLE;
      half_q     <= 4'd0;
      shift_q    <= '0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      sicaklik_q <= '0;
      gecerli_q  <= 1'b0;
      hata_q     <= 1'b0;
    end else begin
      gecerli_q <= 1'b0;
      case (state_q)
        BEKLE:
          if (per_q == PER_LAST) begin
            state_q <= SECIM;
            cs_n_q  <= 1'b0;
          end
        SECIM:
          if (tick) state_q <= KAYDIR;
        KAYDIR:
          if (tick) begin
            sclk_q <= ~sclk_q;
            half_q <= half_q + 4'd1;
            // sample on the edge that raises sclk
            if (!sclk_q) shift_q <= {shift_q[FRAME_BITS-2:0], bus.sensor_sdo};
            // half_q wraps back to 0 after the 16th half-period, ready for the next frame
            if (half_q == 4'd15) begin
              state_q <= BITIR;
              cs_n_q  <= 1'b1;
            end
          end
        BITIR: begin
          state_q <= BEKLE;
          if (^shift_q) begin
            sicaklik_q <= shift_q[FRAME_BITS-1:1];
            gecerli_q  <= 1'b1;
            hata_q     <= 1'b0;
          end else hata_q <= 1'b1;
        end
      endcase
    end
  assign bus.sensor_cs_n = cs_n_q;
  assign bus.sensor_sclk = sclk_q;
  assign bus.sicaklik    = sicaklik_q;
  assign bus.gecerli     = gecerli_q;
  assign bus.hata        = hata_q;
endmodule

// File: tb/tb_sensor_okuyucu.sv
// tb_sensor_okuyucu: randomized frames against a period/phase-based behavioural model plus literal checkpoints
module tb_sensor_okuyucu;
  localparam int D = 2;
  localparam int P = 40;
  logic saat = 1'b0;
  logic reset = 1'b1;
  sensor_okuyucu_if bus ();
  sensor_okuyucu #(.CLK_DIV(D), .PERIOD(P)) dut (.saat(saat), .reset(reset), .bus(bus));
  always #5 saat = ~saat;
  int vectors = 0;
  int miscompares = 0;
  int c = 0;
  int idx = 0;
  logic [7:0] frames[$];
  logic [7:0] sent_frame = 8'h00;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;
  logic [6:0] exp_s = 7'd0;
  logic exp_h = 1'b0;
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask
  function automatic logic [7:0] rand_frame();
    logic [6:0] d;
    logic bad;
    d = 7'($urandom);
    bad = ($urandom_range(0, 3) == 0);
    return {d, ~(^d) ^ bad};
  endfunction
  task automatic wait_c(input int t);
    int n = 0;
    while (c != t && n < 20000) begin
      @(negedge saat);
      n++;
    end
    chk("wait_cycle", c, t);
  endtask
  // sensor: loads a frame when cs_n falls, advances one bit per sclk falling edge
  always @(posedge saat) begin
    if (reset) c = 0;
    else c++;
    #1;
    if (bus.sensor_cs_n) idx = 0;
    else if (prev_cs) begin
      sent_frame = (frames.size() != 0) ? frames.pop_front() : rand_frame();
      idx = 0;
    end else if (prev_sclk && !bus.sensor_sclk) idx++;
    prev_cs = bus.sensor_cs_n;
    prev_sclk = bus.sensor_sclk;
    bus.sensor_sdo = (idx < 8) ? sent_frame[3'(7 - idx)] : 1'b0;
  end
  // model: every output follows from the cycle count since reset release
  always @(negedge saat) begin
    int p;
    logic cs_e, sclk_e, g_e;
    p = c % P;
    if (reset) begin
      exp_s = 7'd0;
      exp_h = 1'b0;
      g_e = 1'b0;
      cs_e = 1'b1;
      sclk_e = 1'b0;
    end else begin
      cs_e = !(c >= P && p < 17 * D);
      sclk_e = c >= P && p >= 2 * D && p < 17 * D && ((p - 2 * D) / D) % 2 == 0;
      g_e = 1'b0;
      if (c >= P && p == 17 * D + 1) begin
        g_e = ^sent_frame;
        exp_h = ~(^sent_frame);
        if (g_e) exp_s = sent_frame[7:1];
      end
    end
    chk("cs_n", bus.sensor_cs_n, cs_e);
    chk("sclk", bus.sensor_sclk, sclk_e);
    chk("gecerli", bus.gecerli, g_e);
    chk("sicaklik", bus.sicaklik, exp_s);
    chk("hata", bus.hata, exp_h);
  end
  initial begin
    frames = '{8'h54, 8'hFF, 8'h01, 8'h03, 8'hFE, 8'h80, 8'h55};
    bus.sensor_sdo = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge saat);
    reset = 1'b0;
    wait_c(39);  chk("cs_n_before_first", bus.sensor_cs_n, 1);
    wait_c(40);  chk("cs_n_first_fall", bus.sensor_cs_n, 0);
    wait_c(74);  chk("cs_n_low_34", bus.sensor_cs_n, 1);
    wait_c(75);  chk("g_54", bus.gecerli, 1); chk("s_54", bus.sicaklik, 42); chk("h_54", bus.hata, 0);
    wait_c(115); chk("g_ff", bus.gecerli, 0); chk("s_ff", bus.sicaklik, 42); chk("h_ff", bus.hata, 1);
    wait_c(155); chk("g_01", bus.gecerli, 1); chk("s_01", bus.sicaklik, 0); chk("h_01", bus.hata, 0);
    wait_c(195); chk("g_03", bus.gecerli, 0); chk("s_03", bus.sicaklik, 0); chk("h_03", bus.hata, 1);
    wait_c(235); chk("g_fe", bus.gecerli, 1); chk("s_fe", bus.sicaklik, 127); chk("h_fe", bus.hata, 0);
    wait_c(275); chk("g_80", bus.gecerli, 1); chk("s_80", bus.sicaklik, 64);
    wait_c(293); chk("sclk_before_reset", bus.sensor_sclk, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_cs_n", bus.sensor_cs_n, 1);
    chk("async_sclk", bus.sensor_sclk, 0);
    chk("async_sicaklik", bus.sicaklik, 0);
    chk("async_gecerli", bus.gecerli, 0);
    repeat (2) @(negedge saat);
    reset = 1'b0;
    wait_c(39);  chk("cs_n_before_restart", bus.sensor_cs_n, 1);
    wait_c(40);  chk("cs_n_restart_fall", bus.sensor_cs_n, 0);
    wait_c(200 * P + 40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
